sprite_pixel_fetch: RTL and testbench

- Downstream consumer of the Mario sprite address generator and upstream source of its animation-frame index.
- Registers the sprite ROM address and absorbs the ROM read latency.
- Expands the returned palette index to 24-bit RGB and delays the video timing signals so they stay pixel-aligned.
- Runs the animation state machine that selects which 512-word frame the address generator indexes. The frame only changes on a video-frame boundary.

---
 rtl/sprite_pixel_fetch.sv | 230 +++++++++++++++++++++++
 tb/tb_sprite_pixel_fetch.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch
//   Sits between the Mario sprite address generator and the sprite BRAM.
//   It registers the ROM address and absorbs the BRAM read latency. It expands
//   the returned RRRGGGBB palette index to RGB888. It delays the video timing
//   by the same PIPE = ROM_LATENCY + 2 cycles, so the timing stays aligned with
//   the pixel. It also runs the animation FSM that picks the 512-word frame
//   the address generator indexes. The frame changes only on a video-frame
//   tick (hcount == 0 && vcount == 0), so the image never tears mid-frame.
//
// Optional build macro: SPRITE_MIRROR_EN
//   Defined   : facing_left_in mirrors the column bits of the ROM address.
//   Undefined : facing_left_in is ignored.
//   Latency is the same in both builds.
//
// Ports
//   pixel_clk_in, rst_n_in          pixel clock, async active-low reset
//   hcount_in, vcount_in            raster position (11 / 10 bits)
//   hsync_in, vsync_in, blank_in    video timing
//   in_sprite_in, image_addr_in     sprite-box flag and ROM address
//   moving_in, airborne_in          Mario motion status
//   collision_in                    enemy hit (pulse or level)
//   facing_left_in                  mirror request (SPRITE_MIRROR_EN only)
//   rom_addr_out, rom_data_in       sprite BRAM interface
//   frame_index_out                 animation frame for the address generator
//   pixel_out, pixel_valid_out      RGB888 and opaque-pixel flag
//   hcount_out .. blank_out         timing delayed by PIPE cycles
//
// Animation states
//   state | meaning
//   IDLE  | standing still, frame 0
//   WALK  | moving on the ground, frames 1->2->3->1, FRAME_HOLD ticks each
//   JUMP  | airborne, frame 4
//   DEAD  | collision seen, frame 5, held until reset

module sprite_pixel_fetch #(
  parameter int          WIDTH       = 16,
  parameter int          HEIGHT      = 256,
  parameter int          ROM_LATENCY = 2,
  parameter int          FRAME_HOLD  = 6,
  parameter logic [7:0]  TRANSPARENT = 8'h00,
  localparam int         ADDR_W      = $clog2(WIDTH*HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_n_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
  input  logic              in_sprite_in,
  input  logic [ADDR_W-1:0] image_addr_in,
  input  logic              moving_in,
  input  logic              airborne_in,
  input  logic              collision_in,
  input  logic              facing_left_in,
  output logic [ADDR_W-1:0] rom_addr_out,
  input  logic [7:0]        rom_data_in,
  output logic [2:0]        frame_index_out,
  output logic [23:0]       pixel_out,
  output logic              pixel_valid_out,
  output logic [10:0]       hcount_out,
  output logic [9:0]        vcount_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              blank_out
);

  localparam int PIPE   = ROM_LATENCY + 2;
  localparam int COL_W  = $clog2(WIDTH);
  localparam int HOLD_W = $clog2(FRAME_HOLD + 1);

  // One bit wider than the address, so the compare is against the real ROM
  // size even when that size fills the address space.
  localparam logic [ADDR_W:0] ROM_WORDS = (ADDR_W+1)'(WIDTH*HEIGHT);

  typedef struct packed {
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hsync;
    logic        vsync;
    logic        blank;
  } timing_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2,
    DEAD = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Address qualification and optional mirroring
  // ---------------------------------------------------------------------------
  logic              addr_qual;
  logic [ADDR_W-1:0] addr_map;

  assign addr_qual = in_sprite_in && ({1'b0, image_addr_in} < ROM_WORDS);

  always_comb begin
    addr_map = image_addr_in;
`ifdef SPRITE_MIRROR_EN
    // WIDTH is a power of two, so WIDTH-1-col is the bitwise inverse of col.
    if (facing_left_in)
      addr_map[COL_W-1:0] = ~image_addr_in[COL_W-1:0];
`endif
  end

`ifndef SPRITE_MIRROR_EN
  logic unused_facing_left;
  assign unused_facing_left = facing_left_in;
`endif

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      rom_addr_out <= '0;
    else
      rom_addr_out <= addr_qual ? addr_map : '0;
  end

  // ---------------------------------------------------------------------------
  // Timing / qualifier delay lines
  // timing_pipe[k] holds the timing sampled k+1 cycles ago. The qualifier only
  // has to reach the stage where rom_data_in returns (index ROM_LATENCY).
  // ---------------------------------------------------------------------------
  timing_t              timing_pipe [PIPE];
  logic [ROM_LATENCY:0] qual_pipe;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < PIPE; i++)
        timing_pipe[i] <= '0;
      qual_pipe <= '0;
    end else begin
      timing_pipe[0] <= '{hcount: hcount_in, vcount: vcount_in,
                          hsync: hsync_in, vsync: vsync_in, blank: blank_in};
      for (int i = 1; i < PIPE; i++)
        timing_pipe[i] <= timing_pipe[i-1];
      qual_pipe[0] <= addr_qual;
      for (int i = 1; i <= ROM_LATENCY; i++)
        qual_pipe[i] <= qual_pipe[i-1];
    end
  end

  assign hcount_out = timing_pipe[PIPE-1].hcount;
  assign vcount_out = timing_pipe[PIPE-1].vcount;
  assign hsync_out  = timing_pipe[PIPE-1].hsync;
  assign vsync_out  = timing_pipe[PIPE-1].vsync;
  assign blank_out  = timing_pipe[PIPE-1].blank;

  // ---------------------------------------------------------------------------
  // Colour expansion and output gating
  // ---------------------------------------------------------------------------
  function automatic logic [23:0] expand_rgb(input logic [7:0] idx);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = idx[7:5];
    g = idx[4:2];
    b = idx[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

  logic pix_valid_nxt;

  // rom_data_in belongs to the pixel whose qualifier and blank sit at stage
  // ROM_LATENCY right now.
  assign pix_valid_nxt = qual_pipe[ROM_LATENCY]
                      && (rom_data_in != TRANSPARENT)
                      && !timing_pipe[ROM_LATENCY].blank;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pixel_out       <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      pixel_valid_out <= pix_valid_nxt;
      pixel_out       <= pix_valid_nxt ? expand_rgb(rom_data_in) : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Animation FSM
  // ---------------------------------------------------------------------------
  logic              frame_tick;
  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              coll_sticky;

  assign frame_tick = (hcount_in == '0) && (vcount_in == '0);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      frame_index_out <= 3'd0;
      hold_cnt        <= '0;
      coll_sticky     <= 1'b0;
    end else if (frame_tick) begin
      // The sticky flag is used up here. A hit on the tick cycle itself counts
      // too, so a one-cycle pulse that lands on the tick is not lost.
      coll_sticky <= 1'b0;
      if (state == DEAD || coll_sticky || collision_in) begin
        state           <= DEAD;
        frame_index_out <= 3'd5;
        hold_cnt        <= '0;
      end else if (airborne_in) begin
        state           <= JUMP;
        frame_index_out <= 3'd4;
        hold_cnt        <= '0;
      end else if (moving_in) begin
        state <= WALK;
        if (state != WALK) begin
          frame_index_out <= 3'd1;
          hold_cnt        <= '0;
        end else if (hold_cnt == HOLD_W'(FRAME_HOLD - 1)) begin
          frame_index_out <= (frame_index_out == 3'd3) ? 3'd1 : frame_index_out + 3'd1;
          hold_cnt        <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        state           <= IDLE;
        frame_index_out <= 3'd0;
        hold_cnt        <= '0;
      end
    end else if (collision_in) begin
      coll_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench for sprite_pixel_fetch. A behavioural model predicts
// every output on every cycle. Directed cases cover reset, latency,
// transparency, range, the walk cycle, priority and mirroring.
module tb_sprite_pixel_fetch;

  localparam int WIDTH  = 16;
  // The ROM is shorter than the 12-bit address space, so out-of-range addresses exist.
  localparam int HEIGHT = 250;
  localparam int AREA   = WIDTH * HEIGHT;
  localparam int FH     = 6;
  localparam int PIPE   = 4;
  localparam int AW     = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [10:0]   hcount_in;
  logic [9:0]    vcount_in;
  logic          hsync_in, vsync_in, blank_in, in_sprite_in;
  logic [AW-1:0] image_addr_in;
  logic          moving_in, airborne_in, collision_in, facing_left_in;
  logic [AW-1:0] rom_addr_out;
  logic [7:0]    rom_data_in;
  logic [2:0]    frame_index_out;
  logic [23:0]   pixel_out;
  logic          pixel_valid_out;
  logic [10:0]   hcount_out;
  logic [9:0]    vcount_out;
  logic          hsync_out, vsync_out, blank_out;

  always #5 clk = ~clk;

  sprite_pixel_fetch #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .pixel_clk_in    (clk),
    .rst_n_in        (rst_n),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .hsync_in        (hsync_in),
    .vsync_in        (vsync_in),
    .blank_in        (blank_in),
    .in_sprite_in    (in_sprite_in),
    .image_addr_in   (image_addr_in),
    .moving_in       (moving_in),
    .airborne_in     (airborne_in),
    .collision_in    (collision_in),
    .facing_left_in  (facing_left_in),
    .rom_addr_out    (rom_addr_out),
    .rom_data_in     (rom_data_in),
    .frame_index_out (frame_index_out),
    .pixel_out       (pixel_out),
    .pixel_valid_out (pixel_valid_out),
    .hcount_out      (hcount_out),
    .vcount_out      (vcount_out),
    .hsync_out       (hsync_out),
    .vsync_out       (vsync_out),
    .blank_out       (blank_out)
  );

  // Sprite BRAM: data appears two cycles after the address.
  logic [7:0] rom [0:4095];
  logic [7:0] rom_d1, rom_d2;
  always @(posedge clk) begin
    rom_d1 <= rom[rom_addr_out];
    rom_d2 <= rom_d1;
  end
  assign rom_data_in = rom_d2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic          hs, vs, bl, ins;
    logic [AW-1:0] addr;
    logic          fl;
  } in_rec;

  in_rec h [PIPE];   // h[0] = inputs sampled at the latest edge
  int    m_frame;
  int    walk_n;     // ticks spent walking, -1 when not walking
  bit    m_dead, m_coll;

  function automatic bit qualified(input in_rec r);
    return r.ins && (int'(r.addr) < AREA);
  endfunction

  function automatic int eff_addr(input in_rec r);
    int a;
    if (!qualified(r)) return 0;
    a = int'(r.addr);
`ifdef SPRITE_MIRROR_EN
    if (r.fl) a = (a / WIDTH) * WIDTH + (WIDTH - 1 - (a % WIDTH));
`endif
    return a;
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] d);
    int r, g, b;
    r = int'(d[7:5]);
    g = int'(d[4:2]);
    b = int'(d[1:0]);
    return {8'(r*32 + r*4 + r/2), 8'(g*32 + g*4 + g/2), 8'(b*85)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < PIPE; i++) h[i] = '0;
    m_frame = 0; walk_n = -1; m_dead = 0; m_coll = 0;
  endtask

  task automatic model_fsm();
    if (hcount_in == 0 && vcount_in == 0) begin
      if (m_dead || m_coll || collision_in) begin
        m_dead = 1; m_frame = 5; walk_n = -1;
      end else if (airborne_in) begin
        m_frame = 4; walk_n = -1;
      end else if (moving_in) begin
        walk_n++;
        m_frame = 1 + (walk_n / FH) % 3;
      end else begin
        m_frame = 0; walk_n = -1;
      end
      m_coll = 0;
    end else if (collision_in) begin
      m_coll = 1;
    end
  endtask

  // One clock: record inputs, advance the model, then check every output.
  task automatic step();
    in_rec r, o;
    int    e;
    bit    q;
    @(posedge clk);
    r = '{hc: hcount_in, vc: vcount_in, hs: hsync_in, vs: vsync_in, bl: blank_in,
          ins: in_sprite_in, addr: image_addr_in, fl: facing_left_in};
    for (int i = PIPE-1; i > 0; i--) h[i] = h[i-1];
    h[0] = r;
    model_fsm();
    #1;
    chk("rom_addr", 32'(rom_addr_out), 32'(eff_addr(h[0])));
    o = h[PIPE-1];
    e = eff_addr(o);
    q = qualified(o) && (rom[e] != 8'h00) && !o.bl;
    chk("pix_valid", 32'(pixel_valid_out), 32'(q));
    chk("pixel", 32'(pixel_out), q ? 32'(expand(rom[e])) : 32'd0);
    chk("hcount_out", 32'(hcount_out), 32'(o.hc));
    chk("vcount_out", 32'(vcount_out), 32'(o.vc));
    chk("hsync_out", 32'(hsync_out), 32'(o.hs));
    chk("vsync_out", 32'(vsync_out), 32'(o.vs));
    chk("blank_out", 32'(blank_out), 32'(o.bl));
    chk("frame", 32'(frame_index_out), 32'(m_frame));
  endtask

  task automatic quiet();
    hcount_in = 11'd1; vcount_in = 10'd1;
    hsync_in = 0; vsync_in = 0; blank_in = 0; in_sprite_in = 0;
    image_addr_in = '0; facing_left_in = 0; collision_in = 0;
  endtask

  task automatic rand_inputs();
    hcount_in      = 11'($urandom_range(1, 2047));
    vcount_in      = 10'($urandom_range(0, 1023));
    hsync_in       = 1'($urandom);
    vsync_in       = 1'($urandom);
    blank_in       = ($urandom_range(0, 3) == 0);
    in_sprite_in   = 1'($urandom);
    image_addr_in  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(AREA, 4095))
                                                 : AW'($urandom_range(0, AREA-1));
    facing_left_in = 1'($urandom);
    collision_in   = 0;
  endtask

  task automatic tick();
    quiet();
    hcount_in = 0; vcount_in = 0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_addr"},  32'(rom_addr_out), 0);
    chk({tag, "_pix"},   32'(pixel_out), 0);
    chk({tag, "_vld"},   32'(pixel_valid_out), 0);
    chk({tag, "_frame"}, 32'(frame_index_out), 0);
    chk({tag, "_hcnt"},  32'(hcount_out), 0);
    chk({tag, "_vcnt"},  32'(vcount_out), 0);
    chk({tag, "_hs"},    32'(hsync_out), 0);
    chk({tag, "_vs"},    32'(vsync_out), 0);
    chk({tag, "_blank"}, 32'(blank_out), 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rom[i] = 8'h00;
    end
    rom[37] = 8'hE0;
    rom[38] = 8'h00;
    rom[39] = 8'h01;

    // Reset
    rst_n = 1; quiet(); moving_in = 0; airborne_in = 0;
    model_reset();
    #1 rst_n = 0;
    #2 check_all_zero("rst");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();

    // Address and pixel latency
    quiet(); hcount_in = 11'd123; vcount_in = 10'd45; in_sprite_in = 1; image_addr_in = 12'd37;
    step();
    chk("addr37", 32'(rom_addr_out), 32'd37);
    quiet(); step(); step();
    chk("lat_early_vld", 32'(pixel_valid_out), 0);
    step();
    chk("lat_pix", 32'(pixel_out), 32'hFF0000);
    chk("lat_vld", 32'(pixel_valid_out), 1);
    chk("lat_hcnt", 32'(hcount_out), 32'd123);

    // Blue-only index, transparency, blanking, range edges
    quiet(); in_sprite_in = 1; image_addr_in = 12'd39; step();
    quiet(); repeat (3) step();
    chk("blue55", 32'(pixel_out), 32'h000055);
    quiet(); in_sprite_in = 1; image_addr_in = 12'd38; step();
    quiet(); repeat (3) step();
    chk("transp_vld", 32'(pixel_valid_out), 0);
    chk("transp_pix", 32'(pixel_out), 0);
    quiet(); in_sprite_in = 1; image_addr_in = 12'd37; blank_in = 1; step();
    quiet(); repeat (3) step();
    chk("blank_vld", 32'(pixel_valid_out), 0);
    quiet(); in_sprite_in = 1; image_addr_in = 12'(AREA - 1); step();
    chk("range_last", 32'(rom_addr_out), 32'(AREA - 1));
    quiet(); in_sprite_in = 1; image_addr_in = 12'(AREA); step();
    chk("range_out_addr", 32'(rom_addr_out), 0);
    quiet(); repeat (3) step();
    chk("range_out_vld", 32'(pixel_valid_out), 0);
    chk("range_out_pix", 32'(pixel_out), 0);

    // Walk cycle
    moving_in = 0; airborne_in = 0;
    tick();
    moving_in = 1;
    for (int k = 0; k < 20; k++) begin
      repeat (4) begin quiet(); step(); end
      tick();
      chk("walk_frame", 32'(frame_index_out), 32'(1 + (k / FH) % 3));
    end

    // Randomized traffic, collisions excluded
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        airborne_in = ($urandom_range(0, 4) == 0);
        moving_in   = ($urandom_range(0, 3) != 0);
      end
      repeat (9) begin rand_inputs(); step(); end
      rand_inputs(); hcount_in = 0; vcount_in = 0; step();
    end

    // Priority: collision pulse with airborne between ticks gives DEAD
    moving_in = 0; airborne_in = 1;
    quiet(); step();
    collision_in = 1; step();
    collision_in = 0; repeat (3) step();
    tick();
    chk("dead", 32'(frame_index_out), 32'd5);
    airborne_in = 0;
    for (int k = 0; k < 3; k++) begin
      repeat (3) begin quiet(); step(); end
      tick();
      chk("dead_hold", 32'(frame_index_out), 32'd5);
    end

    // Reset mid-stream
    repeat (3) begin rand_inputs(); in_sprite_in = 1; step(); end
    rst_n = 0;
    #2 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    tick();
    chk("post_rst_idle", 32'(frame_index_out), 0);
    moving_in = 1;
    tick();
    chk("post_rst_walk", 32'(frame_index_out), 32'd1);
    moving_in = 0;

    // Mirror request
    quiet(); in_sprite_in = 1; image_addr_in = 12'd517; facing_left_in = 1;
    step();
`ifdef SPRITE_MIRROR_EN
    chk("mirror", 32'(rom_addr_out), 32'd522);
`else
    chk("mirror", 32'(rom_addr_out), 32'd517);
`endif
    quiet(); repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
